fetch_pc_predictor: RTL and testbench

Fetch-stage PC generator that sits directly upstream of the branch target buffer. It drives the BTB lookup PC and consumes btb_hit/predicted_target to choose the next fetch PC. It carries each fetch's prediction down to the execute stage and compares it with the resolved outcome. On a mispredict it flushes and redirects, and it produces the BTB update_* signals plus saturating branch/mispredict counters.

---
 rtl/fetch_pc_predictor_if.sv | 35 +++
 rtl/fetch_pc_predictor.sv | 135 +++++++++++++
 tb/tb_fetch_pc_predictor.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_predictor_if.sv
// Fetch-side bus of the PC predictor: BTB lookup, EX resolution feedback,
// BTB update write port and performance counters.
interface fetch_pc_predictor_if #(
  parameter int unsigned CNT_W = 16
);
  logic              stall_i;
  logic [31:0]       lookup_pc;
  logic              btb_hit;
  logic [31:0]       predicted_target;
  logic [31:0]       pc_o;
  logic              ex_is_ctrl;
  logic              ex_taken;
  logic [31:0]       ex_target;
  logic              flush_o;
  logic              update_en;
  logic [31:0]       update_pc;
  logic              update_taken;
  logic [31:0]       update_target;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  // master: the predictor itself
  modport master (
    input  stall_i, btb_hit, predicted_target, ex_is_ctrl, ex_taken, ex_target,
    output lookup_pc, pc_o, flush_o, update_en, update_pc, update_taken,
           update_target, branch_cnt, mispred_cnt
  );

  // slave: BTB, pipeline and execute stage around the predictor
  modport slave (
    output stall_i, btb_hit, predicted_target, ex_is_ctrl, ex_taken, ex_target,
    input  lookup_pc, pc_o, flush_o, update_en, update_pc, update_taken,
           update_target, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/fetch_pc_predictor.sv
// Fetch PC generator: follows BTB predictions, tracks each fetch to EX,
// redirects on mispredict and emits BTB updates plus saturating counters.
module fetch_pc_predictor #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fetch_pc_predictor_if.master  bus
);

  localparam int unsigned EX = PIPE_DEPTH - 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]                  pc_q, pc_d;
  logic [PIPE_DEPTH-1:0]        vld_q, vld_d;
  logic [PIPE_DEPTH-1:0][31:0]  tpc_q, tpc_d;
  logic [PIPE_DEPTH-1:0]        ptk_q, ptk_d;
  logic [PIPE_DEPTH-1:0][31:0]  ptg_q, ptg_d;
  logic                         upd_en_q, upd_en_d;
  logic [31:0]                  upd_pc_q, upd_pc_d;
  logic                         upd_tk_q, upd_tk_d;
  logic [31:0]                  upd_tg_q, upd_tg_d;
  logic [CNT_W-1:0]             br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]             mp_cnt_q, mp_cnt_d;

  logic        resolve;
  logic        ctrl_mis;
  logic        alias_hit;
  logic        mispredict;
  logic [31:0] ex_pc_plus4;
  logic [31:0] redirect_pc;

  always_comb begin
    resolve     = !bus.stall_i && vld_q[EX];
    ex_pc_plus4 = tpc_q[EX] + 32'd4;
    ctrl_mis    = bus.ex_is_ctrl &&
                  ((bus.ex_taken != ptk_q[EX]) ||
                   (bus.ex_taken && (bus.ex_target != ptg_q[EX])));
    // Non-control instruction the BTB claimed was taken: fall through instead.
    alias_hit   = !bus.ex_is_ctrl && ptk_q[EX];
    mispredict  = resolve && (ctrl_mis || alias_hit);
    redirect_pc = (bus.ex_is_ctrl && bus.ex_taken) ? bus.ex_target : ex_pc_plus4;
  end

  always_comb begin
    pc_d = pc_q;
    if (mispredict)        pc_d = redirect_pc;
    else if (bus.stall_i)  pc_d = pc_q;
    else if (bus.btb_hit)  pc_d = bus.predicted_target;
    else                   pc_d = pc_q + 32'd4;
  end

  always_comb begin
    vld_d = vld_q;
    tpc_d = tpc_q;
    ptk_d = ptk_q;
    ptg_d = ptg_q;
    if (!bus.stall_i) begin
      vld_d[0] = !mispredict;
      tpc_d[0] = pc_q;
      ptk_d[0] = bus.btb_hit;
      ptg_d[0] = bus.btb_hit ? bus.predicted_target : '0;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        vld_d[i] = vld_q[i-1] && !mispredict;
        tpc_d[i] = tpc_q[i-1];
        ptk_d[i] = ptk_q[i-1];
        ptg_d[i] = ptg_q[i-1];
      end
    end
  end

  always_comb begin
    upd_en_d = resolve && (bus.ex_is_ctrl || alias_hit);
    upd_pc_d = upd_pc_q;
    upd_tk_d = upd_tk_q;
    upd_tg_d = upd_tg_q;
    if (resolve && bus.ex_is_ctrl) begin
      upd_pc_d = tpc_q[EX];
      upd_tk_d = bus.ex_taken;
      upd_tg_d = bus.ex_target;
    end else if (resolve && alias_hit) begin
      upd_pc_d = tpc_q[EX];
      upd_tk_d = 1'b0;
      upd_tg_d = ex_pc_plus4;
    end
  end

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (resolve && bus.ex_is_ctrl && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_ONE;
    if (mispredict && (mp_cnt_q != '1))                mp_cnt_d = mp_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      vld_q    <= '0;
      tpc_q    <= '0;
      ptk_q    <= '0;
      ptg_q    <= '0;
      upd_en_q <= 1'b0;
      upd_pc_q <= '0;
      upd_tk_q <= 1'b0;
      upd_tg_q <= '0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      tpc_q    <= tpc_d;
      ptk_q    <= ptk_d;
      ptg_q    <= ptg_d;
      upd_en_q <= upd_en_d;
      upd_pc_q <= upd_pc_d;
      upd_tk_q <= upd_tk_d;
      upd_tg_q <= upd_tg_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.lookup_pc     = pc_q;
  assign bus.flush_o       = mispredict;
  assign bus.update_en     = upd_en_q;
  assign bus.update_pc     = upd_pc_q;
  assign bus.update_taken  = upd_tk_q;
  assign bus.update_target = upd_tg_q;
  assign bus.branch_cnt    = br_cnt_q;
  assign bus.mispred_cnt   = mp_cnt_q;

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: per-cycle PC/flush checks in the
// stimulus thread, BTB update transactions checked by a queue-driven monitor.
module tb_fetch_pc_predictor;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fetch_pc_predictor_if #(.CNT_W(2)) bus ();

  fetch_pc_predictor #(
    .RESET_PC   (32'h0000_0000),
    .PIPE_DEPTH (2),
    .CNT_W      (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } upd_t;

  upd_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_no, act, exp);
    end
  endtask

  task automatic push_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_t e;
    e.pc = pc; e.taken = taken; e.tgt = tgt;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge: drive one cycle of inputs, check combinational outputs.
  task automatic cyc(input logic st, input logic hit, input logic [31:0] ptgt,
                     input logic ctrl, input logic tkn, input logic [31:0] etgt,
                     input logic [31:0] exp_pc, input logic exp_fl);
    bus.stall_i          = st;
    bus.btb_hit          = hit;
    bus.predicted_target = ptgt;
    bus.ex_is_ctrl       = ctrl;
    bus.ex_taken         = tkn;
    bus.ex_target        = etgt;
    #1;
    chk("pc_o", bus.pc_o, exp_pc);
    chk("lookup_pc", bus.lookup_pc, exp_pc);
    chk("flush_o", {31'b0, bus.flush_o}, {31'b0, exp_fl});
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic chk_cnt(input logic [1:0] br, input logic [1:0] mp);
    chk("branch_cnt", {30'b0, bus.branch_cnt}, {30'b0, br});
    chk("mispred_cnt", {30'b0, bus.mispred_cnt}, {30'b0, mp});
  endtask

  // Monitor: every update pulse must match the oldest expected update.
  initial begin
    upd_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.update_en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL update_unexpected (cycle %0d): got pc=%h taken=%0b tgt=%h, expected no update",
                   cyc_no, bus.update_pc, bus.update_taken, bus.update_target);
        end else begin
          e = exp_q.pop_front();
          if (bus.update_pc !== e.pc || bus.update_taken !== e.taken || bus.update_target !== e.tgt) begin
            n_fail++;
            $display("FAIL update (cycle %0d): got pc=%h taken=%0b tgt=%h, expected pc=%h taken=%0b tgt=%h",
                     cyc_no, bus.update_pc, bus.update_taken, bus.update_target, e.pc, e.taken, e.tgt);
          end
        end
      end
    end
  end

  initial begin
    reset_n              = 1'b0;
    bus.stall_i          = 1'b0;
    bus.btb_hit          = 1'b0;
    bus.predicted_target = '0;
    bus.ex_is_ctrl       = 1'b0;
    bus.ex_taken         = 1'b0;
    bus.ex_target        = '0;
    repeat (2) @(negedge clk);

    chk("rst pc_o", bus.pc_o, 32'h0);
    chk("rst flush_o", {31'b0, bus.flush_o}, 32'h0);
    chk("rst update_en", {31'b0, bus.update_en}, 32'h0);
    chk("rst update_pc", bus.update_pc, 32'h0);
    chk("rst update_taken", {31'b0, bus.update_taken}, 32'h0);
    chk("rst update_target", bus.update_target, 32'h0);
    chk_cnt(2'd0, 2'd0);
    reset_n = 1'b1;

    // Sequential fetch, then a correctly predicted taken branch at 0x8
    cyc(0, 0, 0,      0, 0, 0, 32'h0,   0);
    cyc(0, 0, 0,      0, 0, 0, 32'h4,   0);
    cyc(0, 1, 32'h100, 0, 0, 0, 32'h8,  0);
    cyc(0, 0, 0,      0, 0, 0, 32'h100, 0);
    push_upd(32'h8, 1'b1, 32'h100);
    cyc(0, 0, 0,      1, 1, 32'h100, 32'h104, 0);
    chk_cnt(2'd1, 2'd0);
    cyc(0, 0, 0,      0, 0, 0, 32'h108, 0);
    chk("update_en drop", {31'b0, bus.update_en}, 32'h0);
    chk("update_pc hold", bus.update_pc, 32'h8);

    // Predicted not-taken at 0x108 resolves taken to 0x40
    cyc(0, 0, 0,      0, 0, 0, 32'h10C, 0);
    push_upd(32'h108, 1'b1, 32'h40);
    cyc(0, 0, 0,      1, 1, 32'h40, 32'h110, 1);
    // Squashed slots: EX inputs must be ignored
    cyc(0, 0, 0,      1, 1, 32'h999, 32'h40, 0);
    chk_cnt(2'd2, 2'd1);
    cyc(0, 0, 0,      1, 1, 32'h999, 32'h44, 0);

    // BTB alias: predicted taken at 0x48, resolves as non-control; concurrent hit loses
    cyc(0, 1, 32'h80, 0, 0, 0, 32'h48, 0);
    cyc(0, 0, 0,      0, 0, 0, 32'h80, 0);
    push_upd(32'h48, 1'b0, 32'h4C);
    cyc(0, 1, 32'h200, 0, 0, 0, 32'h84, 1);
    chk_cnt(2'd2, 2'd2);
    cyc(0, 0, 0,      0, 0, 0, 32'h4C, 0);
    cyc(0, 0, 0,      0, 0, 0, 32'h50, 0);

    // Stall over a would-be mispredict of 0x4C
    cyc(1, 0, 0,      1, 1, 32'h300, 32'h54, 0);
    cyc(1, 0, 0,      1, 1, 32'h300, 32'h54, 0);
    cyc(1, 0, 0,      1, 1, 32'h300, 32'h54, 0);
    chk_cnt(2'd2, 2'd2);
    chk("stall update_en", {31'b0, bus.update_en}, 32'h0);
    push_upd(32'h4C, 1'b1, 32'h300);
    cyc(0, 0, 0,      1, 1, 32'h300, 32'h54, 1);
    chk_cnt(2'd3, 2'd3);

    // Two more mispredicts: counters stay saturated
    cyc(0, 0, 0,      0, 0, 0, 32'h300, 0);
    cyc(0, 0, 0,      0, 0, 0, 32'h304, 0);
    push_upd(32'h300, 1'b1, 32'h500);
    cyc(0, 0, 0,      1, 1, 32'h500, 32'h308, 1);
    cyc(0, 0, 0,      0, 0, 0, 32'h500, 0);
    cyc(0, 0, 0,      0, 0, 0, 32'h504, 0);
    push_upd(32'h500, 1'b1, 32'h600);
    cyc(0, 0, 0,      1, 1, 32'h600, 32'h508, 1);
    chk_cnt(2'd3, 2'd3);

    // PC wrap through 0xFFFF_FFFC
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h600, 0);
    cyc(0, 0, 0,      0, 0, 0, 32'hFFFF_FFFC, 0);

    // Correct resolution of 0x600, then async reset drops its pending update
    bus.ex_is_ctrl = 1'b1;
    bus.ex_taken   = 1'b1;
    bus.ex_target  = 32'hFFFF_FFFC;
    #1;
    chk("wrap pc_o", bus.pc_o, 32'h0);
    chk("wrap flush_o", {31'b0, bus.flush_o}, 32'h0);
    @(posedge clk);
    #2;
    chk("pre-rst update_en", {31'b0, bus.update_en}, 32'h1);
    chk("pre-rst pc_o", bus.pc_o, 32'h4);
    reset_n = 1'b0;
    #1;
    chk("async rst pc_o", bus.pc_o, 32'h0);
    chk("async rst update_en", {31'b0, bus.update_en}, 32'h0);
    chk("async rst flush_o", {31'b0, bus.flush_o}, 32'h0);
    chk_cnt(2'd0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, 0, 0,      0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0,      0, 0, 0, 32'h4, 0);
    repeat (2) @(negedge clk);

    chk("pending updates", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
